// File: rtl/mcp3_rrarb04.sv
`default_nettype none
// ============================================================================
// Module  : mcp3_rrarb04
// Purpose : 4-requester round-robin arbiter with registered one-hot grant held
//           until acknowledged, plus sticky protocol-error flags.
// Rev     : 1.0
// ============================================================================
module mcp3_rrarb04 #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       gnt_ack,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] gnt_encoded,
  output logic       gnt_error,
  output logic [2:0] error_status
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit         TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [8:0] TO_LIMIT = 9'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  enc_q, enc_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [2:0]  err_q, err_d;
  logic [7:0]  tcnt_q, tcnt_d;

  logic        win_found;
  logic [1:0]  win_idx;
  logic [1:0]  cand;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      enc_q   <= 2'd0;
      ptr_q   <= 2'd0;
      err_q   <= 3'b000;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      enc_q   <= enc_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    enc_d     = enc_q;
    ptr_d     = ptr_q;
    err_d     = err_q;
    tcnt_d    = tcnt_q;
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;

    // Scan from farthest to nearest so the nearest set bit after ptr wins.
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end

    case (state_q)
      IDLE: begin
        tcnt_d = 8'd0;
        if (gnt_ack) err_d[0] = 1'b1;
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_idx;
          enc_d   = win_idx;
        end
      end
      GRANT: begin
        if (gnt_ack) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          enc_d   = 2'd0;
          ptr_d   = enc_q + 2'd1;
          tcnt_d  = 8'd0;
        end else begin
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          if (!req[enc_q]) err_d[1] = 1'b1;
          // Counter holds cycles already elapsed; this cycle makes it +1.
          if (TO_EN && (({1'b0, tcnt_q} + 9'd1) >= TO_LIMIT)) err_d[2] = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        enc_d   = 2'd0;
        tcnt_d  = 8'd0;
      end
    endcase
  end

  assign gnt          = gnt_q;
  assign gnt_valid    = |gnt_q;
  assign gnt_encoded  = enc_q;
  assign error_status = err_q;
  assign gnt_error    = |err_q;

endmodule
`default_nettype wire

// File: tb/tb_mcp3_rrarb04.sv
`default_nettype none
// ============================================================================
// Module  : tb_mcp3_rrarb04
// Purpose : Directed vector bench for the round-robin arbiter.
// Rev     : 1.0
// ============================================================================
module tb_mcp3_rrarb04;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic       gnt_ack;

  logic [3:0] gnt,   gnt_n;
  logic       gv,    gv_n;
  logic [1:0] enc,   enc_n;
  logic       gerr,  gerr_n;
  logic [2:0] est,   est_n;

  int errors = 0;
  int checks = 0;

  mcp3_rrarb04 #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .req(req), .gnt_ack(gnt_ack),
    .gnt(gnt), .gnt_valid(gv), .gnt_encoded(enc),
    .gnt_error(gerr), .error_status(est)
  );

  mcp3_rrarb04 #(.TIMEOUT_CYCLES(0)) dut_nt (
    .clock(clock), .reset(reset), .req(req), .gnt_ack(gnt_ack),
    .gnt(gnt_n), .gnt_valid(gv_n), .gnt_encoded(enc_n),
    .gnt_error(gerr_n), .error_status(est_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic       ack;
    logic [3:0] e_gnt;
    logic [1:0] e_enc;
    logic [2:0] e_err;
  } vec_t;

  vec_t vecs[30];

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic a);
    reset   = r;
    req     = rq;
    gnt_ack = a;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input int idx, input logic [3:0] eg, input logic [1:0] ee, input logic [2:0] er);
    check("gnt",          idx, {4'h0, gnt},  {4'h0, eg});
    check("gnt_encoded",  idx, {6'h0, enc},  {6'h0, ee});
    check("gnt_valid",    idx, {7'h0, gv},   {7'h0, |eg});
    check("error_status", idx, {5'h0, est},  {5'h0, er});
    check("gnt_error",    idx, {7'h0, gerr}, {7'h0, |er});
  endtask

  initial begin
    // Each row: inputs held for one clock, expected outputs right after that edge.
    // T1: rotation with req=1111, one idle cycle between grants
    vecs[0]  = '{1'b1, 4'h0, 1'b0, 4'b0000, 2'd0, 3'b000};
    vecs[1]  = '{1'b0, 4'hF, 1'b0, 4'b0001, 2'd0, 3'b000};
    vecs[2]  = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 3'b000};
    vecs[3]  = '{1'b0, 4'hF, 1'b0, 4'b0010, 2'd1, 3'b000};
    vecs[4]  = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 3'b000};
    vecs[5]  = '{1'b0, 4'hF, 1'b0, 4'b0100, 2'd2, 3'b000};
    vecs[6]  = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 3'b000};
    vecs[7]  = '{1'b0, 4'hF, 1'b0, 4'b1000, 2'd3, 3'b000};
    vecs[8]  = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 3'b000};
    vecs[9]  = '{1'b0, 4'hF, 1'b0, 4'b0001, 2'd0, 3'b000};
    vecs[10] = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 3'b000};
    // T2: single high requester, pointer wraps to 0
    vecs[11] = '{1'b1, 4'h0, 1'b0, 4'b0000, 2'd0, 3'b000};
    vecs[12] = '{1'b0, 4'h8, 1'b0, 4'b1000, 2'd3, 3'b000};
    vecs[13] = '{1'b0, 4'h8, 1'b1, 4'b0000, 2'd0, 3'b000};
    vecs[14] = '{1'b0, 4'h9, 1'b0, 4'b0001, 2'd0, 3'b000};
    vecs[15] = '{1'b0, 4'h9, 1'b1, 4'b0000, 2'd0, 3'b000};
    // T3: ack without grant is sticky until reset
    vecs[16] = '{1'b1, 4'h0, 1'b0, 4'b0000, 2'd0, 3'b000};
    vecs[17] = '{1'b0, 4'h0, 1'b1, 4'b0000, 2'd0, 3'b001};
    vecs[18] = '{1'b0, 4'h0, 1'b0, 4'b0000, 2'd0, 3'b001};
    vecs[19] = '{1'b1, 4'h0, 1'b0, 4'b0000, 2'd0, 3'b000};
    // T4: request dropped while granted; grant held until ack
    vecs[20] = '{1'b0, 4'h4, 1'b0, 4'b0100, 2'd2, 3'b000};
    vecs[21] = '{1'b0, 4'h0, 1'b0, 4'b0100, 2'd2, 3'b010};
    vecs[22] = '{1'b0, 4'h0, 1'b0, 4'b0100, 2'd2, 3'b010};
    vecs[23] = '{1'b0, 4'h0, 1'b1, 4'b0000, 2'd0, 3'b010};
    vecs[24] = '{1'b1, 4'h0, 1'b0, 4'b0000, 2'd0, 3'b000};
    // T6: reset mid-grant, pointer back to 0
    vecs[25] = '{1'b0, 4'h2, 1'b0, 4'b0010, 2'd1, 3'b000};
    vecs[26] = '{1'b1, 4'h2, 1'b0, 4'b0000, 2'd0, 3'b000};
    vecs[27] = '{1'b0, 4'hF, 1'b0, 4'b0001, 2'd0, 3'b000};
    vecs[28] = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 3'b000};
    vecs[29] = '{1'b1, 4'h0, 1'b0, 4'b0000, 2'd0, 3'b000};

    reset = 1'b1; req = 4'h0; gnt_ack = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 30; i++) begin
      step(vecs[i].rst, vecs[i].rq, vecs[i].ack);
      check_all(i, vecs[i].e_gnt, vecs[i].e_enc, vecs[i].e_err);
      check("nt_gnt", i, {4'h0, gnt_n}, {4'h0, vecs[i].e_gnt});
    end

    // T5: grant never acked; timeout of 4 visible on grant cycle 5
    step(1'b0, 4'h1, 1'b0);
    check_all(100, 4'b0001, 2'd0, 3'b000);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 4'h1, 1'b0);
      check_all(100 + k, 4'b0001, 2'd0, (k >= 4) ? 3'b100 : 3'b000);
      check("nt_error_status", 100 + k, {5'h0, est_n}, 8'h00);
    end
    step(1'b0, 4'h1, 1'b1);
    check_all(111, 4'b0000, 2'd0, 3'b100);
    step(1'b1, 4'h0, 1'b0);
    check_all(112, 4'b0000, 2'd0, 3'b000);

    // Ack in IDLE with a pending request: flagged, arbitration still proceeds
    step(1'b0, 4'h4, 1'b1);
    check_all(113, 4'b0100, 2'd2, 3'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
